// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, coordinate width and
// total-length helpers used by the raster generator and the overlay blocks.
package vga_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } raster_state_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_raster_gen_if.sv
// Raster timing bundle driven by vga_raster_gen and consumed by the overlay
// blocks and the VGA connector pins.
interface vga_raster_gen_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic               vid_active;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [7:0]         frame_cnt;

  modport master (
    output x_cnt, y_cnt, vid_active, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    input x_cnt, y_cnt, vid_active, hsync, vsync, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter with registered sync decode. Used once
// for the horizontal (dot) axis and once for the vertical (line) axis.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic               clk_dot,
  input  logic               reset_n,
  input  logic               step,
  input  logic               clear,
  output logic [COORD_W-1:0] cnt,
  output logic               active,
  output logic               sync,
  output logic               wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL > MAX_TOTAL) begin : g_param_check
    $error("vga_axis_cnt: every timing parameter must be >=1 and the total <= 4096");
  end

  localparam logic [COORD_W:0]   ACT_END  = (COORD_W+1)'(ACTIVE);
  localparam logic [COORD_W:0]   SYNC_BEG = (COORD_W+1)'(ACTIVE + FP);
  localparam logic [COORD_W:0]   SYNC_END = (COORD_W+1)'(ACTIVE + FP + SYNC);
  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic               sync_q, sync_d;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = wrap ? '0 : cnt_q + COORD_W'(1);
    end
  end

  // Decodes describe the position being loaded, so they line up with cnt after the edge.
  always_comb begin
    active = 1'b0;
    sync_d = ~POL;
    if (!clear) begin
      active = ({1'b0, cnt_d} < ACT_END);
      if ({1'b0, cnt_d} >= SYNC_BEG && {1'b0, cnt_d} < SYNC_END) begin
        sync_d = POL;
      end
    end
  end

  always_ff @(posedge clk_dot or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster timing generator: dot/line counters, active-video qualifier,
// sync pulses and line/frame markers, all registered and mutually aligned.
module vga_raster_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic                    clk_dot,
  input  logic                    reset_n,
  input  logic                    en,
  vga_raster_gen_if.master        vif
);

  raster_state_e state_q, state_d;

  logic               h_step, h_clear, h_active, h_sync, h_wrap;
  logic               v_step, v_clear, v_active, v_sync, v_wrap;
  logic [COORD_W-1:0] h_cnt, v_cnt;

  logic       vid_active_q, vid_active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk_dot or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = en ? ST_RUN : ST_IDLE;
  end

  // The first enabled edge out of IDLE loads (0,0) without stepping.
  always_comb begin
    h_clear       = ~en;
    v_clear       = ~en;
    h_step        = en && (state_q == ST_RUN);
    v_step        = h_step && h_wrap;
    line_start_d  = en && ((state_q == ST_IDLE) || h_wrap);
    frame_start_d = en && ((state_q == ST_IDLE) || (h_wrap && v_wrap));
    vid_active_d  = h_active && v_active;
    frame_cnt_d   = frame_cnt_q;
    if (v_step && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL)
  ) u_h_axis (
    .clk_dot (clk_dot),
    .reset_n (reset_n),
    .step    (h_step),
    .clear   (h_clear),
    .cnt     (h_cnt),
    .active  (h_active),
    .sync    (h_sync),
    .wrap    (h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL)
  ) u_v_axis (
    .clk_dot (clk_dot),
    .reset_n (reset_n),
    .step    (v_step),
    .clear   (v_clear),
    .cnt     (v_cnt),
    .active  (v_active),
    .sync    (v_sync),
    .wrap    (v_wrap)
  );

  always_ff @(posedge clk_dot or negedge reset_n) begin
    if (!reset_n) begin
      vid_active_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      vid_active_q  <= vid_active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vif.x_cnt       = h_cnt;
  assign vif.y_cnt       = v_cnt;
  assign vif.vid_active  = vid_active_q;
  assign vif.hsync       = h_sync;
  assign vif.vsync       = v_sync;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen on a reduced 14x8 raster; a linear dot-index
// reference model supplies the expected outputs for every clock.
module tb_vga_raster_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk_dot = 1'b0;
  logic reset_n;
  logic en;

  int checks = 0;
  int errors = 0;

  bit m_run;
  int m_pos;
  int m_fc;

  vga_raster_gen_if vif ();

  vga_raster_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL    (1'b0), .V_POL (1'b0)
  ) dut (
    .clk_dot (clk_dot),
    .reset_n (reset_n),
    .en      (en),
    .vif     (vif)
  );

  always #5 clk_dot = ~clk_dot;

  function automatic logic [40:0] observe();
    return {vif.x_cnt, vif.y_cnt, vif.vid_active, vif.hsync, vif.vsync,
            vif.line_start, vif.frame_start, vif.frame_cnt};
  endfunction

  function automatic logic [40:0] exp_vec();
    int x, y;
    logic va, hs, vs, ls, fs;
    if (!m_run) return {24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(m_fc)};
    x  = m_pos % HT;
    y  = m_pos / HT;
    va = (x < HA) && (y < VA);
    hs = !((x >= HA + HF) && (x < HA + HF + HS));
    vs = !((y >= VA + VF) && (y < VA + VF + VS));
    ls = (x == 0);
    fs = (m_pos == 0);
    return {12'(x), 12'(y), va, hs, vs, ls, fs, 8'(m_fc)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_fc  = 0;
  endtask

  task automatic model_step(input logic en_v);
    if (!reset_n) begin
      model_reset();
    end else if (!en_v) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == FRAME) begin
        m_pos = 0;
        m_fc  = (m_fc + 1) % 256;
      end
    end
  endtask

  // Called from a falling edge; returns on the next falling edge.
  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge clk_dot);
    model_step(en_v);
    @(negedge clk_dot);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    repeat (3) @(negedge clk_dot);
    model_reset();
    checks++;
    if (observe() !== exp_vec())
      begin errors++; $display("FAIL reset_vec got %h want %h", observe(), exp_vec()); end
    checks++;
    if ({vif.hsync, vif.vsync, vif.frame_cnt} !== {2'b11, 8'd0})
      begin errors++; $display("FAIL reset_sync got hs=%b vs=%b fc=%0d want 1 1 0", vif.hsync, vif.vsync, vif.frame_cnt); end
    reset_n = 1'b1;
    tick(1'b1);
    checks++;
    if ({vif.x_cnt, vif.y_cnt, vif.line_start, vif.frame_start} !== {24'd0, 2'b11})
      begin errors++; $display("FAIL reset_release got x=%0d y=%0d ls=%b fs=%b want 0 0 1 1", vif.x_cnt, vif.y_cnt, vif.line_start, vif.frame_start); end
    checks++;
    if (observe() !== exp_vec())
      begin errors++; $display("FAIL reset_release_vec got %h want %h", observe(), exp_vec()); end
  endtask

  task automatic test_line_timing();
    int hs_lo = 0, va_n = 0, bad_x = 0;
    for (int i = 0; i < HT; i++) begin
      tick(1'b1);
      checks++;
      if (observe() !== exp_vec())
        begin errors++; $display("FAIL line_vec i=%0d got %h want %h", i, observe(), exp_vec()); end
      if (!vif.hsync) begin
        hs_lo++;
        if (vif.x_cnt < 12'd10 || vif.x_cnt > 12'd12) bad_x++;
      end
      if (vif.vid_active) va_n++;
    end
    checks++;
    if (hs_lo !== 3 || bad_x !== 0)
      begin errors++; $display("FAIL line_hsync got %0d low (%0d misplaced) want 3 at x 10..12", hs_lo, bad_x); end
    checks++;
    if (va_n !== 8)
      begin errors++; $display("FAIL line_active got %0d want 8", va_n); end
    checks++;
    if ({vif.x_cnt, vif.y_cnt} !== {12'd0, 12'd1})
      begin errors++; $display("FAIL line_wrap got x=%0d y=%0d want 0 1", vif.x_cnt, vif.y_cnt); end
  endtask

  task automatic test_frame_timing();
    int vs_lo = 0, va_bad = 0, fs_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      checks++;
      if (observe() !== exp_vec())
        begin errors++; $display("FAIL frame_vec i=%0d got %h want %h", i, observe(), exp_vec()); end
      if (!vif.vsync) vs_lo++;
      if (vif.vid_active && vif.y_cnt >= 12'd4) va_bad++;
      if (vif.frame_start) begin
        fs_n++;
        checks++;
        if ({vif.x_cnt, vif.y_cnt, vif.frame_cnt} !== {24'd0, 8'd1})
          begin errors++; $display("FAIL frame_start_pos got x=%0d y=%0d fc=%0d want 0 0 1", vif.x_cnt, vif.y_cnt, vif.frame_cnt); end
      end
    end
    checks++;
    if (vs_lo !== 28)
      begin errors++; $display("FAIL frame_vsync got %0d low dots want 28", vs_lo); end
    checks++;
    if (va_bad !== 0)
      begin errors++; $display("FAIL frame_blank_active got %0d want 0", va_bad); end
    checks++;
    if (fs_n !== 1 || vif.frame_cnt !== 8'd1)
      begin errors++; $display("FAIL frame_count got fs=%0d fc=%0d want 1 1", fs_n, vif.frame_cnt); end
  endtask

  task automatic test_frame_wrap();
    int fs_n = 0;
    bit saw_wrap = 1'b0;
    logic [7:0] prev_fc = vif.frame_cnt;
    for (int i = 0; i < 256 * FRAME; i++) begin
      tick(1'b1);
      checks++;
      if (observe() !== exp_vec())
        begin errors++; $display("FAIL wrap_vec i=%0d got %h want %h", i, observe(), exp_vec()); end
      if (vif.frame_start) fs_n++;
      if (prev_fc == 8'd255 && vif.frame_cnt == 8'd0) saw_wrap = 1'b1;
      prev_fc = vif.frame_cnt;
    end
    checks++;
    if (fs_n !== 256)
      begin errors++; $display("FAIL wrap_fs_count got %0d want 256", fs_n); end
    checks++;
    if (!saw_wrap || vif.frame_cnt !== 8'd1)
      begin errors++; $display("FAIL wrap_fc got wrap_seen=%0d fc=%0d want 1 1", saw_wrap, vif.frame_cnt); end
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    int fc_keep;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (vif.x_cnt == 12'd5 && vif.y_cnt == 12'd2) found = 1'b1;
      else tick(1'b1);
    end
    checks++;
    if (!found)
      begin errors++; $display("FAIL en_seek got x=%0d y=%0d want 5 2 within budget", vif.x_cnt, vif.y_cnt); end
    fc_keep = m_fc;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      checks++;
      if (observe() !== exp_vec())
        begin errors++; $display("FAIL en_idle i=%0d got %h want %h", i, observe(), exp_vec()); end
    end
    tick(1'b1);
    checks++;
    if ({vif.x_cnt, vif.y_cnt, vif.line_start, vif.frame_start, vif.frame_cnt} !== {24'd0, 2'b11, 8'(fc_keep)})
      begin errors++; $display("FAIL en_restart got x=%0d y=%0d fs=%b fc=%0d want 0 0 1 %0d", vif.x_cnt, vif.y_cnt, vif.frame_start, vif.frame_cnt, fc_keep); end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (vif.x_cnt == 12'd11 && vif.y_cnt == 12'd6) found = 1'b1;
      else tick(1'b1);
    end
    checks++;
    if (!found)
      begin errors++; $display("FAIL arst_seek got x=%0d y=%0d want 11 6 within budget", vif.x_cnt, vif.y_cnt); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (observe() !== {24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0})
      begin errors++; $display("FAIL arst_immediate got %h want %h", observe(), {24'd0, 5'b01100, 8'd0}); end
    @(negedge clk_dot);
    tick(1'b1);
    checks++;
    if (observe() !== exp_vec())
      begin errors++; $display("FAIL arst_hold got %h want %h", observe(), exp_vec()); end
    reset_n = 1'b1;
    tick(1'b1);
    checks++;
    if (observe() !== exp_vec() || !vif.frame_start)
      begin errors++; $display("FAIL arst_release got %h want %h", observe(), exp_vec()); end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      checks++;
      if (observe() !== exp_vec())
        begin errors++; $display("FAIL rand_en i=%0d en=%b got %h want %h", i, en, observe(), exp_vec()); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    model_reset();
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_frame_wrap();
    test_enable_drop();
    test_async_reset();
    test_random_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
